serial_addsub: RTL



---
 rtl/serial_addsub_if.sv | 33 +++
 rtl/serial_addsub.sv | 101 ++++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Bus bundle for serial_addsub.
//   master : drives start, sub, a, b; observes status, serial stream and result
//   slave  : the adder/subtractor itself
// Ports carried:
//   start, sub, a, b          - operation request and operands
//   busy, bit_out, bit_valid  - status and LSB-first serial result stream
//   done, sum, carry_out,
//   overflow                  - completion pulse and held result/flags
interface serial_addsub_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             bit_out;
   logic             bit_valid;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, sub, a, b,
      input  busy, bit_out, bit_valid, done, sum, carry_out, overflow
   );

   modport slave (
      input  start, sub, a, b,
      output busy, bit_out, bit_valid, done, sum, carry_out, overflow
   );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, one bit per clock, LSB first.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; aborts any operation in flight
//   bus   - serial_addsub_if slave: start/sub/a/b in; busy, bit_out, bit_valid,
//           done, sum, carry_out, overflow out
// An operation takes WIDTH RUN cycles followed by one DONE cycle. sum and the
// flags are held until the next completion.
module serial_addsub #(
   parameter int unsigned  WIDTH = 4,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input logic            clk,
   input logic            rst_n,
   serial_addsub_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] opa_q, opb_q, res_q, sum_q;
   logic             carry_q, cout_q, ovf_q;
   logic [CNT_W-1:0] cnt_q;

   logic s_bit, c_bit, last;

   // Full-adder cell on the current LSBs.
   assign s_bit = opa_q[0] ^ opb_q[0] ^ carry_q;
   assign c_bit = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
   assign last  = (cnt_q == CNT_W'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StRun;
         StRun:   if (last) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  // Subtraction is a + ~b + 1: invert B and seed the carry.
                  opa_q   <= bus.a;
                  opb_q   <= bus.sub ? ~bus.b : bus.b;
                  carry_q <= bus.sub;
                  cnt_q   <= '0;
               end
            end
            StRun: begin
               opa_q   <= opa_q >> 1;
               opb_q   <= opb_q >> 1;
               res_q   <= {s_bit, res_q[WIDTH-1:1]};
               carry_q <= c_bit;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last) begin
                  // carry_q is the MSB carry-in here; overflow is in XOR out.
                  sum_q  <= {s_bit, res_q[WIDTH-1:1]};
                  cout_q <= c_bit;
                  ovf_q  <= carry_q ^ c_bit;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.bit_valid = (state_q == StRun);
   assign bus.bit_out   = (state_q == StRun) & s_bit;
   assign bus.done      = (state_q == StDone);
   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
   assign bus.overflow  = ovf_q;

endmodule
